// File: rtl/usart_tx_sequencer.sv
`timescale 1ns/1ps
// USART transmit sequencer: pops bytes from the TX FIFO head and serialises
// start, data (LSB first), optional parity and stop bits on baud_tick.
module usart_tx_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             cp2,
    input  logic             ireset,
    input  logic             txen,
    input  logic             baud_tick,
    input  logic [1:0]       ucsz,
    input  logic [1:0]       upm,
    input  logic             usbs,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_re,
    output logic             txd,
    output logic             tx_busy,
    output logic             txc_set
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             stop_cnt, stop_cnt_n;
    logic             par, par_n;
    logic [1:0]       cfg_ucsz, cfg_ucsz_n;
    logic [1:0]       cfg_upm, cfg_upm_n;
    logic             cfg_usbs, cfg_usbs_n;
    logic             txd_n;
    logic             pop;
    logic             load;
    logic             last_data;
    logic             last_stop;

    // Reset blocks any pop or completion pulse in its own cycle.
    assign pop       = txen && !fifo_empty && !ireset;
    assign last_data = (cnt == (CNT_W'(4) + CNT_W'(cfg_ucsz)));
    assign last_stop = (stop_cnt == cfg_usbs);

    // Next-state, datapath and combinational handshake outputs.
    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        cnt_n      = cnt;
        stop_cnt_n = stop_cnt;
        par_n      = par;
        cfg_ucsz_n = cfg_ucsz;
        cfg_upm_n  = cfg_upm;
        cfg_usbs_n = cfg_usbs;
        load       = 1'b0;
        txc_set    = 1'b0;

        case (state)
            IDLE: begin
                if (pop) begin
                    load    = 1'b1;
                    state_n = ALIGN;
                end
            end
            ALIGN: begin
                if (baud_tick) state_n = START;
            end
            START: begin
                if (baud_tick) begin
                    state_n = DATA;
                    cnt_n   = '0;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shreg_n = shreg >> 1;
                    par_n   = par ^ shreg[0];
                    if (last_data) begin
                        state_n    = cfg_upm[1] ? PARITY : STOP;
                        stop_cnt_n = 1'b0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    state_n    = STOP;
                    stop_cnt_n = 1'b0;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (!last_stop) begin
                        stop_cnt_n = 1'b1;
                    end else if (pop) begin
                        load    = 1'b1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                        txc_set = !ireset;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // A pop captures the head word and freezes the frame format.
        if (load) begin
            shreg_n    = fifo_dout;
            cfg_ucsz_n = ucsz;
            cfg_upm_n  = upm;
            cfg_usbs_n = usbs;
            par_n      = 1'b0;
            cnt_n      = '0;
            stop_cnt_n = 1'b0;
        end
        fifo_re = load;

        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shreg_n[0];
            PARITY:  txd_n = par_n ^ cfg_upm_n[0];
            default: txd_n = 1'b1;
        endcase
    end

    // State and datapath registers; txd/tx_busy follow the entered state.
    always_ff @(posedge cp2) begin
        if (ireset) begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= '0;
            stop_cnt <= 1'b0;
            par      <= 1'b0;
            cfg_ucsz <= 2'b00;
            cfg_upm  <= 2'b00;
            cfg_usbs <= 1'b0;
            txd      <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            cnt      <= cnt_n;
            stop_cnt <= stop_cnt_n;
            par      <= par_n;
            cfg_ucsz <= cfg_ucsz_n;
            cfg_upm  <= cfg_upm_n;
            cfg_usbs <= cfg_usbs_n;
            txd      <= txd_n;
            tx_busy  <= (state_n != IDLE);
        end
    end

endmodule
